sha_digest_tx_serializer: RTL and testbench

Upstream feeder for `uart_tx`. It latches a 256-bit SHA-256 digest from the hash core and streams it, most-significant byte first, to the UART transmitter one byte at a time using the `uart_tx` handshake. Bytes go out either as raw binary or as lowercase ASCII hex followed by CR LF, so results can be read on a host terminal.

---
 rtl/sha_uart_pkg.sv | 23 ++
 rtl/hex_nibble_to_ascii.sv | 16 +
 rtl/sha_digest_tx_serializer.sv | 142 ++++++++++++++
 tb/tb_sha_digest_tx_serializer.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/sha_uart_pkg.sv
// Shared types and constants for the SHA digest UART serializer.
// Character totals cover both raw (SHA_TX_HEX_ASCII_EN undefined) and hex builds.
package sha_uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_DONE,
    ST_GAP,
    ST_FINISH
  } ser_state_t;

  localparam int unsigned DIGEST_W    = 256;
  localparam int unsigned RAW_BYTES   = 32;
  localparam int unsigned HEX_NIBBLES = 64;
  localparam int unsigned HEX_CHARS   = 66;
  localparam int unsigned CHAR_CNT_W  = 7;
  localparam int unsigned GAP_CNT_W   = 8;

  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;

endpackage

// File: rtl/hex_nibble_to_ascii.sv
// Combinational nibble-to-lowercase-ASCII-hex encoder ('0'-'9', 'a'-'f').
module hex_nibble_to_ascii (
  input  logic [3:0] nibble,
  output logic [7:0] ascii
);

  always_comb begin
    if (nibble < 4'd10) begin
      ascii = 8'h30 + {4'h0, nibble};
    end else begin
      // 'a' - 10 = 0x57
      ascii = 8'h57 + {4'h0, nibble};
    end
  end

endmodule

// File: rtl/sha_digest_tx_serializer.sv
// Streams a latched 256-bit digest MSB-first into uart_tx, one byte per handshake.
// Define SHA_TX_HEX_ASCII_EN for lowercase hex + CR LF output; raw binary otherwise.
module sha_digest_tx_serializer
  import sha_uart_pkg::*;
#(
  parameter int unsigned INTER_BYTE_GAP = 2
) (
  input  logic           i_Clock,
  input  logic           i_Reset,
  input  logic           i_Digest_DV,
  input  logic [255:0]   i_Digest,
  input  logic           i_Tx_Active,
  input  logic           i_Tx_Done,
  output logic           o_Tx_DV,
  output logic [7:0]     o_Tx_Byte,
  output logic           o_Busy,
  output logic           o_Done,
  output logic           o_Overrun
);

`ifdef SHA_TX_HEX_ASCII_EN
  localparam logic [CHAR_CNT_W-1:0] TOTAL = CHAR_CNT_W'(HEX_CHARS);
`else
  localparam logic [CHAR_CNT_W-1:0] TOTAL = CHAR_CNT_W'(RAW_BYTES);
`endif
  localparam logic [GAP_CNT_W-1:0] GAP_LOAD = GAP_CNT_W'(INTER_BYTE_GAP);

  ser_state_t              state_q, state_d;
  logic [DIGEST_W-1:0]     sr_q, sr_d, sr_adv;
  logic [CHAR_CNT_W-1:0]   cnt_q, cnt_d, cnt_inc;
  logic [GAP_CNT_W-1:0]    gap_q, gap_d;
  logic                    tx_dv_d, busy_d, done_d, overrun_d;
  logic [7:0]              tx_byte_d;
  logic [7:0]              cur_byte;

  assign cnt_inc = cnt_q + 1'b1;

`ifdef SHA_TX_HEX_ASCII_EN
  logic [3:0] nibble;
  logic [7:0] nibble_ascii;

  // Even count = high nibble of the top byte; the byte shifts out after its low nibble.
  assign nibble = cnt_q[0] ? sr_q[251:248] : sr_q[255:252];
  assign sr_adv = cnt_q[0] ? {sr_q[247:0], 8'h00} : sr_q;

  hex_nibble_to_ascii u_hex_nibble_to_ascii (
    .nibble (nibble),
    .ascii  (nibble_ascii)
  );

  always_comb begin
    if (cnt_q == CHAR_CNT_W'(HEX_NIBBLES)) begin
      cur_byte = ASCII_CR;
    end else if (cnt_q == CHAR_CNT_W'(HEX_NIBBLES + 1)) begin
      cur_byte = ASCII_LF;
    end else begin
      cur_byte = nibble_ascii;
    end
  end
`else
  assign cur_byte = sr_q[255:248];
  assign sr_adv   = {sr_q[247:0], 8'h00};
`endif

  always_comb begin
    state_d   = state_q;
    sr_d      = sr_q;
    cnt_d     = cnt_q;
    gap_d     = gap_q;
    tx_dv_d   = 1'b0;
    tx_byte_d = o_Tx_Byte;
    busy_d    = o_Busy;
    done_d    = 1'b0;
    overrun_d = o_Overrun | (i_Digest_DV && (state_q != ST_IDLE));

    unique case (state_q)
      ST_IDLE: begin
        if (i_Digest_DV) begin
          sr_d    = i_Digest;
          cnt_d   = '0;
          gap_d   = '0;
          busy_d  = 1'b1;
          state_d = ST_GAP;
        end
      end
      ST_GAP: begin
        if (gap_q != '0) begin
          gap_d = gap_q - 1'b1;
        end else if (!i_Tx_Active) begin
          // o_Tx_DV is registered, so it is raised on entry to ISSUE.
          tx_dv_d   = 1'b1;
          tx_byte_d = cur_byte;
          state_d   = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        state_d = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        if (i_Tx_Done) begin
          cnt_d   = cnt_inc;
          sr_d    = sr_adv;
          gap_d   = GAP_LOAD;
          state_d = (cnt_inc == TOTAL) ? ST_FINISH : ST_GAP;
        end
      end
      ST_FINISH: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      state_q   <= ST_IDLE;
      sr_q      <= '0;
      cnt_q     <= '0;
      gap_q     <= '0;
      o_Tx_DV   <= 1'b0;
      o_Tx_Byte <= '0;
      o_Busy    <= 1'b0;
      o_Done    <= 1'b0;
      o_Overrun <= 1'b0;
    end else begin
      state_q   <= state_d;
      sr_q      <= sr_d;
      cnt_q     <= cnt_d;
      gap_q     <= gap_d;
      o_Tx_DV   <= tx_dv_d;
      o_Tx_Byte <= tx_byte_d;
      o_Busy    <= busy_d;
      o_Done    <= done_d;
      o_Overrun <= overrun_d;
    end
  end

endmodule

// File: tb/tb_sha_digest_tx_serializer.sv
// Directed bench for sha_digest_tx_serializer with a uart_tx loopback model (4 clocks/bit).
// Expected characters are queued at digest submission and popped on each o_Tx_DV.
module tb_sha_digest_tx_serializer;

  localparam int unsigned TB_GAP = 0;
  localparam int unsigned CPB    = 4;
  localparam int unsigned FRAME  = 10 * CPB;
`ifdef SHA_TX_HEX_ASCII_EN
  localparam int unsigned N_CHARS = 66;
`else
  localparam int unsigned N_CHARS = 32;
`endif
  localparam logic [255:0] ABC =
    256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         dig_dv = 1'b0;
  logic [255:0] dig = '0;
  logic         tx_active = 1'b0;
  logic         tx_done = 1'b0;
  logic         tx_dv;
  logic [7:0]   tx_byte;
  logic         busy, done, overrun;

  always #5 clk = ~clk;

  sha_digest_tx_serializer #(.INTER_BYTE_GAP(TB_GAP)) dut (
    .i_Clock     (clk),
    .i_Reset     (rst),
    .i_Digest_DV (dig_dv),
    .i_Digest    (dig),
    .i_Tx_Active (tx_active),
    .i_Tx_Done   (tx_done),
    .o_Tx_DV     (tx_dv),
    .o_Tx_Byte   (tx_byte),
    .o_Busy      (busy),
    .o_Done      (done),
    .o_Overrun   (overrun)
  );

  // uart_tx stand-in: no reset; Active high for FRAME cycles, Done on the last of them.
  logic        u_busy = 1'b0;
  int unsigned u_cnt  = 0;
  always @(posedge clk) begin
    if (!u_busy) begin
      tx_done <= 1'b0;
      if (tx_dv) begin
        u_busy    <= 1'b1;
        tx_active <= 1'b1;
        u_cnt     <= 0;
      end
    end else begin
      u_cnt <= u_cnt + 1;
      if (u_cnt == FRAME - 2) tx_done <= 1'b1;
      if (u_cnt == FRAME - 1) begin
        tx_done   <= 1'b0;
        tx_active <= 1'b0;
        u_busy    <= 1'b0;
      end
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          checks = 0;
  int          errors = 0;
  logic [7:0]  exp_q[$];
  logic [7:0]  obs_bytes[66];
  int unsigned nbytes, ndone;
  int          last_done, first_dv, t0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] exp_char(input logic [255:0] d, input int unsigned k);
`ifdef SHA_TX_HEX_ASCII_EN
    logic [3:0] n;
    if (k == 64) return 8'h0D;
    if (k == 65) return 8'h0A;
    n = d[255 - 4*k -: 4];
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h57 + {4'h0, n});
`else
    return d[255 - 8*k -: 8];
`endif
  endfunction

  task automatic step();
    @(negedge clk);
    if (tx_done && nbytes > 0) last_done = cyc;
    if (tx_dv) begin
      chk("dv_while_active", 32'(tx_active), 32'd0);
      if (nbytes == 0) first_dv = cyc;
      else chk("done_to_dv_spacing", 32'(cyc - last_done), 32'(2 + TB_GAP));
      if (nbytes < 66) obs_bytes[nbytes] = tx_byte;
      nbytes++;
      if (exp_q.size() == 0) chk("byte_overflow", 32'(nbytes), 32'(N_CHARS));
      else chk($sformatf("byte%0d", nbytes), 32'(tx_byte), 32'(exp_q.pop_front()));
    end
    if (done) begin
      ndone++;
      chk("done_latency", 32'(cyc - last_done), 32'd2);
      chk("busy_low_at_done", 32'(busy), 32'd0);
    end
  endtask

  task automatic start_stream(input logic [255:0] d);
    nbytes = 0; ndone = 0; last_done = 0; first_dv = 0;
    for (int unsigned k = 0; k < N_CHARS; k++) exp_q.push_back(exp_char(d, k));
    dig = d; dig_dv = 1'b1; t0 = cyc;
    step();
    dig_dv = 1'b0; dig = ~d;
    chk("busy_after_accept", 32'(busy), 32'd1);
  endtask

  task automatic wait_end(input string tag);
    int unsigned n;
    n = 0;
    while (ndone == 0 && n < N_CHARS * (FRAME + 8) + 100) begin step(); n++; end
    chk({tag, "_done_seen"}, 32'(ndone), 32'd1);
    chk({tag, "_char_count"}, 32'(nbytes), 32'(N_CHARS));
    chk({tag, "_queue_drained"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_abc_markers(input string tag);
`ifdef SHA_TX_HEX_ASCII_EN
    chk({tag, "_c1"},  32'(obs_bytes[0]),  32'h62);
    chk({tag, "_c2"},  32'(obs_bytes[1]),  32'h61);
    chk({tag, "_c63"}, 32'(obs_bytes[62]), 32'h61);
    chk({tag, "_c64"}, 32'(obs_bytes[63]), 32'h64);
    chk({tag, "_c65"}, 32'(obs_bytes[64]), 32'h0D);
    chk({tag, "_c66"}, 32'(obs_bytes[65]), 32'h0A);
`else
    chk({tag, "_b1"},  32'(obs_bytes[0]),  32'hBA);
    chk({tag, "_b2"},  32'(obs_bytes[1]),  32'h78);
    chk({tag, "_b32"}, 32'(obs_bytes[31]), 32'hAD);
`endif
  endtask

  initial begin
    logic [255:0] d2, d3;
    int unsigned  n;
    d2 = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    d3 = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};

    repeat (3) @(negedge clk);
    chk("rst_tx_dv",   32'(tx_dv),   32'd0);
    chk("rst_tx_byte", 32'(tx_byte), 32'd0);
    chk("rst_busy",    32'(busy),    32'd0);
    chk("rst_done",    32'(done),    32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Stream 1: known digest, first-byte latency from acceptance.
    start_stream(ABC);
    wait_end("s1");
    chk("s1_first_dv_latency", 32'(first_dv - t0), 32'd2);
    chk("s1_no_overrun", 32'(overrun), 32'd0);
    check_abc_markers("s1");

    // Stream 2: submitted on the o_Done cycle.
    start_stream(d2);
    chk("b2b_no_overrun", 32'(overrun), 32'd0);
    wait_end("s2");
    chk("s2_first_byte", 32'(obs_bytes[0]), 32'(exp_char(d2, 0)));
    chk("s2_no_overrun", 32'(overrun), 32'd0);

    // Stream 3: a second digest arrives mid-stream while byte 5 is in flight.
    start_stream(ABC);
    n = 0;
    while (nbytes < 5 && n < 1000) begin step(); n++; end
    chk("s3_reached_byte5", 32'(nbytes), 32'd5);
    step();
    dig = '1; dig_dv = 1'b1;
    step();
    dig_dv = 1'b0;
    chk("s3_overrun_set", 32'(overrun), 32'd1);
    wait_end("s3");
    check_abc_markers("s3");
    chk("s3_overrun_sticky", 32'(overrun), 32'd1);

    // Stream 4: reset while byte 10 is on the line, then a fresh digest.
    start_stream(d3);
    n = 0;
    while (nbytes < 10 && n < 2000) begin step(); n++; end
    chk("s4_reached_byte10", 32'(nbytes), 32'd10);
    repeat (6) step();
    rst = 1'b1;
    #1;
    chk("midrst_tx_dv",   32'(tx_dv),   32'd0);
    chk("midrst_tx_byte", 32'(tx_byte), 32'd0);
    chk("midrst_busy",    32'(busy),    32'd0);
    chk("midrst_done",    32'(done),    32'd0);
    chk("midrst_overrun", 32'(overrun), 32'd0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    start_stream(ABC);
    wait_end("s5");
    check_abc_markers("s5");
    chk("s5_no_overrun", 32'(overrun), 32'd0);

    repeat (4) @(negedge clk);
    chk("idle_busy_low", 32'(busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
